alsu_cmd_issuer: RTL

//  Upstream issue stage for the ALSU. Buffers packed 16-bit operation commands in a small FIFO (valid/ready in).

---
 rtl/alsu_cmd_issuer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alsu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alsu_cmd_issuer
//   Issue stage in front of the ALSU. Packed 16-bit commands are queued in a
//   small FIFO, popped one per cycle onto registered ALSU drive pins, and
//   tagged. A tag/valid/invalid shift register follows the ALSU pipeline so
//   that res_valid/res_tag/res_invalid line up with the ALSU output.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready = FIFO not full)
//   cmd_data[15:0]      {bypass_B,bypass_A,red_op_B,red_op_A,direction,
//                        serial_in,cin,opcode[2:0],B[2:0],A[2:0]}
//   issue_en            permit a pop/issue this cycle
//   flush               drop every queued (not yet issued) command
//   A,B,opcode,cin,serial_in,direction,red_op_A,red_op_B,bypass_A,bypass_B
//                       registered ALSU drive pins
//   alsu_out[5:0]       ALSU result
//   res_valid/data/tag/invalid   aligned completion of an issued command
//   fifo_count          number of queued commands
// -----------------------------------------------------------------------------
module alsu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [15:0]             cmd_data,
    input  logic                    issue_en,
    input  logic                    flush,
    output logic signed [2:0]       A,
    output logic signed [2:0]       B,
    output logic [2:0]              opcode,
    output logic                    cin,
    output logic                    serial_in,
    output logic                    direction,
    output logic                    red_op_A,
    output logic                    red_op_B,
    output logic                    bypass_A,
    output logic                    bypass_B,
    input  logic [5:0]              alsu_out,
    output logic                    res_valid,
    output logic [5:0]              res_data,
    output logic [3:0]              res_tag,
    output logic                    res_invalid,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       v;
        logic [3:0] tag;
        logic       inv;
    } flight_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   drv_q, drv_d;
    logic [3:0]    tag_q, tag_d;
    flight_t       pipe_q [LATENCY+1];

    logic        full, empty, push, pop;
    logic [15:0] head;
    logic        head_invalid;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    // Flush wins over both push and pop in the same cycle.
    assign push      = cmd_valid && !full && !flush;
    assign pop       = issue_en && !empty && !flush;
    assign head      = mem_q[rd_ptr_q];

    // Opcodes 6/7 are illegal; reduction is only defined for OR/XOR.
    assign head_invalid = ((head[12] | head[13]) & (head[7] | head[8])) | (head[7] & head[8]);

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drv_d    = '0;          // NOP word whenever nothing issues
        tag_d    = tag_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                drv_d    = head;
                tag_d    = tag_q + 4'd1;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drv_q    <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drv_q    <= drv_d;
            tag_q    <= tag_d;
        end
    end

    // Stage 0 shadows the drive registers; the following LATENCY stages track
    // the ALSU input and output registers, so the last stage coincides with
    // the ALSU output that belongs to the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{v: pop, tag: tag_q, inv: head_invalid};
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {bypass_B, bypass_A, red_op_B, red_op_A, direction,
            serial_in, cin, opcode, B, A} = drv_q;

    assign res_valid   = pipe_q[LATENCY].v;
    assign res_tag     = pipe_q[LATENCY].tag;
    assign res_invalid = pipe_q[LATENCY].inv;
    assign res_data    = alsu_out;
    assign fifo_count  = count_q;

endmodule
